// File: rtl/regfile_ctrl_if.sv
// regfile_ctrl_if: issue, register-file, ALU operand/result and status signals of regfile_ctrl
interface regfile_ctrl_if;
  logic       issue_valid_in, issue_wb_in, issue_ready_out;
  logic [2:0] issue_rd_in, issue_sr1_in, issue_sr2_in;
  logic [2:0] sr1_out, sr2_out;
  logic [7:0] sr1_data_in, sr2_data_in;
  logic [7:0] opa_out, opb_out;
  logic       op_valid_out, op_ready_in;
  logic       res_valid_in;
  logic [7:0] res_data_in;
  logic       we_reg_out;
  logic [2:0] rd_out;
  logic [7:0] data_out;
  logic       busy_out, error_out;
  modport master (
    output issue_valid_in, issue_wb_in, issue_rd_in, issue_sr1_in, issue_sr2_in,
    output sr1_data_in, sr2_data_in, op_ready_in, res_valid_in, res_data_in,
    input  issue_ready_out, sr1_out, sr2_out, opa_out, opb_out, op_valid_out,
    input  we_reg_out, rd_out, data_out, busy_out, error_out
  );
  modport slave (
    input  issue_valid_in, issue_wb_in, issue_rd_in, issue_sr1_in, issue_sr2_in,
    input  sr1_data_in, sr2_data_in, op_ready_in, res_valid_in, res_data_in,
    output issue_ready_out, sr1_out, sr2_out, opa_out, opb_out, op_valid_out,
    output we_reg_out, rd_out, data_out, busy_out, error_out
  );
endinterface

// File: rtl/regfile_ctrl.sv
// regfile_ctrl: steps one instruction through operand read, ALU issue, result wait and write-back.
// Build macro REGFILE_CTRL_BYPASS_EN lets WRITE accept the next issue and forward the written result.
module regfile_ctrl (
  input  logic          clka,
  input  logic          reset_in,
  regfile_ctrl_if.slave bus
);
`ifdef REGFILE_CTRL_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, READ, ISSUE, WAIT_RES, WRITE} state_t;
  state_t     state_q;
  logic [2:0] rd_q, sr1_q, sr2_q;
  logic       wb_q, ready_q, op_valid_q, we_q, busy_q, error_q;
  logic [7:0] opa_q, opb_q, data_q;
  logic [3:0] cnt_q;
  logic       take_byp;
  assign take_byp = BYP && state_q == WRITE && bus.issue_valid_in;
  // a bypassed issue must read the register file at its own addresses in the same cycle
  assign bus.sr1_out         = take_byp ? bus.issue_sr1_in : sr1_q;
  assign bus.sr2_out         = take_byp ? bus.issue_sr2_in : sr2_q;
  assign bus.issue_ready_out = ready_q;
  assign bus.opa_out         = opa_q;
  assign bus.opb_out         = opb_q;
  assign bus.op_valid_out    = op_valid_q;
  assign bus.we_reg_out      = we_q;
  assign bus.rd_out          = rd_q;
  assign bus.data_out        = data_q;
  assign bus.busy_out        = busy_q;
  assign bus.error_out       = error_q;
  always_ff @(posedge clka or negedge reset_in)
    if (!reset_in) begin
      state_q    <= IDLE;
      {rd_q, sr1_q, sr2_q, wb_q} <= '0;
      {opa_q, opb_q, data_q}     <= '0;
      cnt_q      <= '0;
      ready_q    <= 1'b1;
      op_valid_q <= 1'b0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.issue_valid_in) begin
          {rd_q, sr1_q, sr2_q, wb_q} <= {bus.issue_rd_in, bus.issue_sr1_in, bus.issue_sr2_in, bus.issue_wb_in};
          state_q <= READ;
          ready_q <= 1'b0;
          busy_q  <= 1'b1;
        end
        READ: begin
          opa_q      <= bus.sr1_data_in;
          opb_q      <= bus.sr2_data_in;
          op_valid_q <= 1'b1;
          state_q    <= ISSUE;
        end
        ISSUE: if (bus.op_ready_in) begin
          op_valid_q <= 1'b0;
          cnt_q      <= '0;
          state_q    <= WAIT_RES;
        end
        // a result arriving in the final (15th) wait cycle still beats the timeout
        WAIT_RES: begin
          cnt_q <= cnt_q + 4'd1;
          if (bus.res_valid_in) begin
            data_q  <= bus.res_data_in;
            state_q <= wb_q ? WRITE : IDLE;
            we_q    <= wb_q;
            busy_q  <= wb_q;
            ready_q <= !wb_q || BYP;
          end else if (cnt_q == 4'd14) begin
            error_q <= 1'b1;
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        WRITE: begin
          we_q <= 1'b0;
          if (take_byp) begin
            {rd_q, sr1_q, sr2_q, wb_q} <= {bus.issue_rd_in, bus.issue_sr1_in, bus.issue_sr2_in, bus.issue_wb_in};
            opa_q      <= bus.issue_sr1_in == rd_q ? data_q : bus.sr1_data_in;
            opb_q      <= bus.issue_sr2_in == rd_q ? data_q : bus.sr2_data_in;
            op_valid_q <= 1'b1;
            ready_q    <= 1'b0;
            state_q    <= ISSUE;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          ready_q    <= 1'b1;
          busy_q     <= 1'b0;
          op_valid_q <= 1'b0;
          we_q       <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_regfile_ctrl.sv
// tb_regfile_ctrl: vector table, randomized transactions against a timeline model, and reset/bypass sequences.
module tb_regfile_ctrl;
`ifdef REGFILE_CTRL_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef struct {
    logic [2:0] rd, s1, s2;
    logic       wb;
    int         dop, dres;
    logic [7:0] res;
    int         exp_we;
    logic       exp_err;
  } vec_t;
  logic       clka = 1'b0, reset_in = 1'b0, rf_load = 1'b0;
  int         n_chk = 0, n_fail = 0, wc;
  logic [7:0] rf [8], exp_rf [8];
  logic       err_exp = 1'b0;
  vec_t       vt [6];
  regfile_ctrl_if bus();
  regfile_ctrl dut (.clka(clka), .reset_in(reset_in), .bus(bus));
  always #5 clka = ~clka;
  always @(posedge clka)
    if (rf_load) rf <= exp_rf;
    else if (bus.we_reg_out) rf[bus.rd_out] <= bus.data_out;
  assign bus.sr1_data_in = rf[bus.sr1_out];
  assign bus.sr2_data_in = rf[bus.sr2_out];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic issue(input logic [2:0] rd, s1, s2, input logic wb);
    bus.issue_valid_in = 1'b1;
    bus.issue_rd_in    = rd;
    bus.issue_sr1_in   = s1;
    bus.issue_sr2_in   = s2;
    bus.issue_wb_in    = wb;
  endtask

  // Cycle c counts clock edges after the accept edge: READ in 1, ISSUE for dop+1 cycles,
  // WAIT_RES for up to 15 cycles (result in wait cycle dres), then WRITE (wb) and IDLE.
  task automatic run_txn(input logic [2:0] rd, s1, s2, input logic wb, input int dop, dres,
                         input logic [7:0] res, output int we_cyc);
    logic to;
    int last, fin;
    logic [7:0] ea, eb;
    to  = dres > 14;
    last = 3 + dop + (to ? 14 : dres);
    fin = last + ((!to && wb) ? 2 : 1);
    ea = exp_rf[s1];
    eb = exp_rf[s2];
    we_cyc = 0;
    chk("accept_ready", bus.issue_ready_out, 1);
    issue(rd, s1, s2, wb);
    for (int c = 1; c <= fin; c++) begin
      tick();
      bus.issue_valid_in = 1'b0;
      bus.issue_rd_in    = 3'($urandom);
      bus.issue_sr1_in   = 3'($urandom);
      bus.issue_sr2_in   = 3'($urandom);
      if (bus.we_reg_out === 1'b1 && we_cyc == 0) we_cyc = c;
      chk("sr1_out", bus.sr1_out, s1);
      chk("sr2_out", bus.sr2_out, s2);
      chk("ready", bus.issue_ready_out, c == fin || (BYP && wb && !to && c == last + 1));
      chk("busy", bus.busy_out, c != fin);
      chk("op_valid", bus.op_valid_out, c >= 2 && c <= 2 + dop);
      chk("we", bus.we_reg_out, !to && wb && c == last + 1);
      chk("error", bus.error_out, err_exp || (to && c > last));
      if (c >= 2 && c <= 2 + dop) begin
        chk("opa", bus.opa_out, ea);
        chk("opb", bus.opb_out, eb);
      end
      if (!to && c == last + 1) begin
        chk("data_out", bus.data_out, res);
        if (wb) chk("rd_out", bus.rd_out, rd);
      end
      bus.op_ready_in  = (c == 2 + dop) ? 1'b1 : (c == 1) ? 1'($urandom) : 1'b0;
      bus.res_valid_in = (c >= 3 + dop) ? (!to && c == 3 + dop + dres) : 1'($urandom);
      bus.res_data_in  = (c == 3 + dop + dres) ? res : 8'($urandom);
    end
    bus.op_ready_in  = 1'b0;
    bus.res_valid_in = 1'b0;
    if (to) err_exp = 1'b1;
    else if (wb) begin
      exp_rf[rd] = res;
      chk("rf_written", rf[rd], res);
    end
  endtask

  initial begin
    exp_rf = '{8'd0, 8'd5, 8'd0, 8'd7, 8'd11, 8'd22, 8'd33, 8'd44};
    vt[0] = '{3'd2, 3'd1, 3'd3, 1'b1, 0, 0,  8'd12,  4,  1'b0};
    vt[1] = '{3'd5, 3'd2, 3'd2, 1'b1, 3, 2,  8'h99,  9,  1'b0};
    vt[2] = '{3'd1, 3'd5, 3'd0, 1'b0, 1, 1,  8'd9,   0,  1'b0};
    vt[3] = '{3'd7, 3'd7, 3'd5, 1'b1, 0, 14, 8'h3C,  18, 1'b0};
    vt[4] = '{3'd6, 3'd0, 3'd1, 1'b1, 2, 15, 8'h55,  0,  1'b1};
    vt[5] = '{3'd4, 3'd6, 3'd7, 1'b1, 0, 3,  8'hA5,  7,  1'b1};
    bus.issue_valid_in = 1'b0;
    bus.issue_wb_in    = 1'b0;
    bus.issue_rd_in    = '0;
    bus.issue_sr1_in   = '0;
    bus.issue_sr2_in   = '0;
    bus.op_ready_in    = 1'b0;
    bus.res_valid_in   = 1'b0;
    bus.res_data_in    = '0;
    rf_load = 1'b1;
    tick();
    tick();
    rf_load = 1'b0;
    chk("rst_ready", bus.issue_ready_out, 1);
    chk("rst_busy", bus.busy_out, 0);
    chk("rst_op_valid", bus.op_valid_out, 0);
    chk("rst_we", bus.we_reg_out, 0);
    chk("rst_error", bus.error_out, 0);
    chk("rst_opa", bus.opa_out, 0);
    chk("rst_data", bus.data_out, 0);
    chk("rst_rd", bus.rd_out, 0);
    chk("rst_sr1", bus.sr1_out, 0);
    reset_in = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      run_txn(vt[i].rd, vt[i].s1, vt[i].s2, vt[i].wb, vt[i].dop, vt[i].dres, vt[i].res, wc);
      chk("vec_we_cycle", wc, vt[i].exp_we);
      chk("vec_error", bus.error_out, vt[i].exp_err);
    end
    for (int i = 0; i < 25; i++)
      run_txn(3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
              ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 4)), 8'($urandom), wc);
    // reset in the middle of ISSUE
    issue(3'd3, 3'd1, 3'd2, 1'b1);
    tick();
    bus.issue_valid_in = 1'b0;
    tick();
    chk("pre_rst_op_valid", bus.op_valid_out, 1);
    reset_in = 1'b0;
    #1;
    chk("rst_issue_ready", bus.issue_ready_out, 1);
    chk("rst_issue_op_valid", bus.op_valid_out, 0);
    chk("rst_issue_busy", bus.busy_out, 0);
    chk("rst_issue_error", bus.error_out, 0);
    tick();
    chk("rst_issue_edge_ready", bus.issue_ready_out, 1);
    chk("rst_issue_edge_we", bus.we_reg_out, 0);
    reset_in = 1'b1;
    err_exp = 1'b0;
    tick();
    // reset in the middle of WRITE must suppress the write
    issue(3'd6, 3'd0, 3'd0, 1'b1);
    tick();
    bus.issue_valid_in = 1'b0;
    tick();
    bus.op_ready_in = 1'b1;
    tick();
    bus.op_ready_in  = 1'b0;
    bus.res_valid_in = 1'b1;
    bus.res_data_in  = 8'hEE;
    tick();
    bus.res_valid_in = 1'b0;
    chk("pre_rst_we", bus.we_reg_out, 1);
    reset_in = 1'b0;
    #1;
    chk("rst_write_we", bus.we_reg_out, 0);
    chk("rst_write_data", bus.data_out, 0);
    tick();
    chk("rst_write_no_wr", rf[6], exp_rf[6]);
    reset_in = 1'b1;
    tick();
    // back-to-back issue reading the register being written
    issue(3'd2, 3'd0, 3'd0, 1'b1);
    tick();
    bus.issue_valid_in = 1'b0;
    tick();
    bus.op_ready_in = 1'b1;
    tick();
    bus.op_ready_in  = 1'b0;
    bus.res_valid_in = 1'b1;
    bus.res_data_in  = 8'h4D;
    tick();
    bus.res_valid_in = 1'b0;
    chk("b2b_we", bus.we_reg_out, 1);
    issue(3'd1, 3'd2, 3'd0, 1'b0);
    exp_rf[2] = 8'h4D;
    tick();
    if (BYP) begin
      bus.issue_valid_in = 1'b0;
      chk("b2b_byp_op_valid", bus.op_valid_out, 1);
      chk("b2b_byp_opa", bus.opa_out, 8'h4D);
    end else begin
      chk("b2b_idle_ready", bus.issue_ready_out, 1);
      chk("b2b_idle_op_valid", bus.op_valid_out, 0);
      tick();
      bus.issue_valid_in = 1'b0;
      tick();
      chk("b2b_op_valid", bus.op_valid_out, 1);
      chk("b2b_opa", bus.opa_out, 8'h4D);
    end
    chk("b2b_opb", bus.opb_out, exp_rf[0]);
    bus.op_ready_in = 1'b1;
    tick();
    bus.op_ready_in  = 1'b0;
    bus.res_valid_in = 1'b1;
    tick();
    bus.res_valid_in = 1'b0;
    chk("b2b_end_ready", bus.issue_ready_out, 1);
    for (int i = 0; i < 8; i++) chk("rf_final", rf[i], exp_rf[i]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_ctrl.md
REGFILE_CTRL -- requirements
Module: regfile_ctrl

Interface
REQ-001 The block SHALL have one clock, clka (input, 1), with all state updated on its rising edge.
REQ-002 The block SHALL have reset_in (input, 1), an asynchronous active-low reset.
REQ-003 The block SHALL have issue_valid_in, issue_wb_in (input, 1 each); issue_ready_out (output, 1); issue_rd_in, issue_sr1_in, issue_sr2_in (input, 3 each) as the instruction issue port.
REQ-004 The block SHALL have sr1_out, sr2_out (output, 3 each) driving the register file read addresses, and sr1_data_in, sr2_data_in (input, 8 each) carrying its combinational read data.
REQ-005 The block SHALL have opa_out, opb_out (output, 8 each), op_valid_out (output, 1) and op_ready_in (input, 1) as the ALU operand port.
REQ-006 The block SHALL have res_valid_in (input, 1) and res_data_in (input, 8) as the ALU result port.
REQ-007 The block SHALL have we_reg_out (output, 1), rd_out (output, 3) and data_out (output, 8) driving the register file write port.
REQ-008 The block SHALL have busy_out (output, 1), high when state != IDLE, and error_out (output, 1), a sticky timeout flag.

Function
REQ-009 The FSM SHALL have the states IDLE, READ, ISSUE, WAIT_RES and WRITE.
REQ-010 In IDLE, issue_ready_out SHALL be 1; on issue_valid_in=1, the block SHALL latch rd, sr1, sr2 and wb and go to READ.
REQ-011 issue_ready_out SHALL be 0 in every state other than IDLE (see REQ-023).
REQ-012 sr1_out and sr2_out SHALL always reflect the latched sr1/sr2.
REQ-013 In READ, the block SHALL capture sr1_data_in into opa_out and sr2_data_in into opb_out, then go to ISSUE (one cycle).
REQ-014 In ISSUE, op_valid_out SHALL be 1, and opa_out/opb_out SHALL stay stable until op_ready_in=1; the block SHALL then go to WAIT_RES.
REQ-015 In WAIT_RES, the block SHALL capture res_data_in into data_out when res_valid_in=1, then go to WRITE if wb=1, else IDLE.
REQ-016 res_valid_in SHALL be ignored in every state other than WAIT_RES.
REQ-017 A 4-bit timeout counter SHALL clear on entry to WAIT_RES and increment each cycle there.
REQ-018 When the timeout counter reaches 15 with res_valid_in=0, error_out SHALL be set (sticky until reset) and the block SHALL return to IDLE with no write.
REQ-019 When res_valid_in=1 in the cycle the counter reaches 15, the result SHALL win and error_out SHALL not be set.
REQ-020 In WRITE, we_reg_out SHALL be 1 for exactly one cycle with rd_out = latched rd; we_reg_out SHALL be 0 in all other states.
REQ-021 Minimum latency from issue accept to we_reg_out SHALL be 4 cycles (READ, ISSUE with op_ready_in=1, WAIT_RES with res_valid_in=1, WRITE).

Reset
REQ-022 When reset_in=0, the block SHALL immediately enter IDLE and clear all outputs and latches to 0 (issue_ready_out=1 once in IDLE, error_out=0), aborting any in-flight instruction with no write, including mid-WRITE.

Configuration
REQ-023 With REGFILE_CTRL_BYPASS_EN defined, WRITE SHALL assert issue_ready_out; on issue_valid_in=1, it SHALL latch the new instruction and go directly to ISSUE, loading opa_out/opb_out from data_out where the new sr1/sr2 equals rd_out, else from sr1_data_in/sr2_data_in.
REQ-024 With REGFILE_CTRL_BYPASS_EN defined and no issue, WRITE SHALL go to IDLE.
REQ-025 Without REGFILE_CTRL_BYPASS_EN, WRITE SHALL always go to IDLE and issue_ready_out SHALL be 0 in WRITE.

Verification
REQ-026 Scenario 1: reset_in=0 mid-ISSUE -> next edge state IDLE, op_valid_out=0, we_reg_out=0, issue_ready_out=1.
REQ-027 Scenario 2: issue rd=2, sr1=1, sr2=3, wb=1; regfile r1=5, r3=7; op_ready_in=1; res 12 after 1 cycle -> opa_out=5, opb_out=7, then we_reg_out=1, rd_out=2, data_out=12 exactly 4 cycles after accept.
REQ-028 Scenario 3: op_ready_in held 0 for 3 cycles -> op_valid_out=1 and opa_out/opb_out unchanged for 3 cycles; issue_ready_out=0 throughout.
REQ-029 Scenario 4: issue with wb=0, res 9 -> we_reg_out never asserts; IDLE one cycle after res_valid_in.
REQ-030 Scenario 5: res_valid_in never asserted -> error_out=1 after 15 WAIT_RES cycles, IDLE, no write; error_out stays 1 until reset.
REQ-031 Scenario 6 (BYPASS_EN): write r2=12 with back-to-back issue sr1=2 (regfile still returns old 0) -> opa_out=12, ISSUE entered directly; without the macro, the issue waits one cycle in IDLE.
